bnn_core_feeder: RTL and testbench
==================================

Name: bnn_core_feeder

Overview:
- Sequencer directly upstream of bnn_core.
- Per output channel: fetches that channel's packed weight word, then streams every input row of the image, channel-interleaved, from on-chip image memory into the core.
- Generates the core's i_valid / i_calc_valid pipeline strobes and tags each result row with its (channel, row) index.
- Runs one full convolution layer per i_start.

Parameters:
IN_CHANNEL, 3, input channels (beats per row)
OUT_CHANNEL, 3, output channels (passes per start)
WEGT_WIDTH, 3, kernel width; rows needed before first calc
IN_DATA_WIDTH, 28, input row width in bits and row count
WEGT_SIZE, 27, packed weight width (WEGT_WIDTH^2*IN_CHANNEL)
CORE_DELAY, 5, width of o_calc_valid
ROW_GAP, 2, idle cycles after each row's reads; legal minimum 2
IMG_AW, 7, image memory address width (covers IN_DATA_WIDTH*IN_CHANNEL words)
WGT_AW, 2, weight memory address width
OUT_ROWS, IN_DATA_WIDTH-WEGT_WIDTH+1 (26), output rows per pass

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_start  in  1  pulse; begins a layer when idle
o_busy  out  1  high from the cycle after i_start acceptance until o_done
o_done  out  1  one-cycle pulse, aligned with the core's final o_valid
o_img_rd_en  out  1  image memory read enable
o_img_addr  out  IMG_AW  address = row*IN_CHANNEL + ch
i_img_rd_data  in  IN_DATA_WIDTH  read data, valid 1 cycle after rd_en
o_wgt_rd_en  out  1  weight memory read enable
o_wgt_addr  out  WGT_AW  = current output channel
i_wgt_rd_data  in  WEGT_SIZE  read data, valid 1 cycle after rd_en
o_weight  out  WEGT_SIZE  to core i_weight; stable for a whole pass
o_data  out  IN_DATA_WIDTH  to core i_data
o_valid  out  1  to core i_valid
o_calc_valid  out  CORE_DELAY  to core i_calc_valid
o_tag_ch  out  WGT_AW  output channel of the row the core emits next
o_tag_row  out  5  output row index of the row the core emits next

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset mid-layer aborts at once; no o_done.
- FSM states: IDLE -> WRD -> WCAP -> ROW -> GAP -> (ROW | WRD | DRAIN) -> IDLE.
- IDLE: i_start accepted here only; ignored in every other state.
- WRD (1 cycle): o_wgt_rd_en=1, o_wgt_addr=ch.
- WCAP (1 cycle): o_weight <= i_wgt_rd_data.
- ROW (IN_CHANNEL cycles): o_img_rd_en=1, channel counter 0..IN_CHANNEL-1, o_img_addr=row*IN_CHANNEL+chan.
- GAP (ROW_GAP cycles):
  - If row < IN_DATA_WIDTH-1: row++ and go to ROW.
  - Else if ch < OUT_CHANNEL-1: ch++, row=0, go to WRD.
  - Else go to DRAIN.
- Data path: o_valid and o_data are the rd_en and read data delayed 1 cycle. The core therefore sees exactly IN_CHANNEL contiguous beats per row, separated by at least ROW_GAP idle cycles. This lets its channel counter reset and its line buffer hold until slicing completes.
- Calc strobes:
  - o_calc_valid[0] pulses the cycle after the last beat of row r, for r >= WEGT_WIDTH-1 only (rows 0 and 1 only prime the buffer).
  - o_calc_valid[k] = o_calc_valid[k-1] delayed 1 cycle.
- Tags: when o_calc_valid[CORE_DELAY-1] is high, o_tag_ch/o_tag_row <= that row's ch and r-(WEGT_WIDTH-1). This aligns the tag with the core's registered o_valid.
- DRAIN: wait until o_calc_valid[CORE_DELAY-1] has fired for the final row. o_done pulses the next cycle, o_busy drops in the same cycle, return to IDLE.
- Pass period: 2 + IN_DATA_WIDTH*(IN_CHANNEL+ROW_GAP) cycles (defaults: 142).
- Stale rows from the previous pass are flushed by the two priming rows; no clear is required.

Decomposition:
- Shared package bnn_pkg: IN_CHANNEL, OUT_CHANNEL, WEGT_WIDTH, IN_DATA_WIDTH, WEGT_SIZE, CORE_DELAY, and the FSM state encoding.
- One natural sub-module: bnn_calc_strobe_gen, the CORE_DELAY-bit shift register plus tag pipeline.

Test Plan:
- Cycle 0 i_start, defaults -> WRD at 1; first img rd at 3 (addr 0,1,2); o_valid at 4–6; first o_calc_valid[0] at 17 (row 2); then every 5 cycles.
- Full layer, defaults -> 78 o_calc_valid[0] pulses; o_weight changes at end of cycles 2, 144, 286; o_done only at cycle 431.
- Address check -> pass 1 row 27 reads addr 81,82,83; o_wgt_addr=1 during pass 1; no addr exceeds 83.
- Tag check with core attached -> first core o_valid at 22 with tag (0,0); last at 431 with tag (2,25); results match a golden XNOR-popcount model.
- i_start re-pulsed at cycles 50 and 300 -> ignored; timing identical to the single-start run.
- reset_n low at cycle 200 for 3 cycles -> all outputs 0 immediately; no o_done; new i_start restarts from pass 0 row 0.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared constants, FSM encoding and address helper for the bnn_core feeder.
package bnn_pkg;

  localparam int IN_CHANNEL    = 3;
  localparam int OUT_CHANNEL   = 3;
  localparam int WEGT_WIDTH    = 3;
  localparam int IN_DATA_WIDTH = 28;
  localparam int WEGT_SIZE     = 27;
  localparam int CORE_DELAY    = 5;
  localparam int ROW_GAP       = 2;
  localparam int IMG_AW        = 7;
  localparam int WGT_AW        = 2;
  localparam int OUT_ROWS      = IN_DATA_WIDTH - WEGT_WIDTH + 1;
  localparam int ROW_W         = 5;
  localparam int CHAN_W        = $clog2(IN_CHANNEL);
  localparam int GAP_W         = $clog2(ROW_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRD   = 3'd1,
    S_WCAP  = 3'd2,
    S_ROW   = 3'd3,
    S_GAP   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  // Image memory holds rows channel-interleaved: row*IN_CHANNEL + chan.
  function automatic logic [IMG_AW-1:0] img_addr(input logic [ROW_W-1:0]  row,
                                                 input logic [CHAN_W-1:0] chan);
    return IMG_AW'(row) * IMG_AW'(IN_CHANNEL) + IMG_AW'(chan);
  endfunction

endpackage

// File: rtl/bnn_calc_strobe_gen.sv
// Calc-valid shift register for the core pipeline, carrying each row's
// (channel, output row) tag alongside so it lands with the core's o_valid.
module bnn_calc_strobe_gen
  import bnn_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fire,
  input  logic [WGT_AW-1:0]     fire_ch,
  input  logic [ROW_W-1:0]      fire_row,
  output logic [CORE_DELAY-1:0] calc_valid,
  output logic [WGT_AW-1:0]     tag_ch,
  output logic [ROW_W-1:0]      tag_row
);

  logic [WGT_AW-1:0] ch_pipe_r  [CORE_DELAY];
  logic [ROW_W-1:0]  row_pipe_r [CORE_DELAY];

  // Strobe and tag pipelines advance together every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      calc_valid <= '0;
      tag_ch     <= '0;
      tag_row    <= '0;
      for (int i = 0; i < CORE_DELAY; i++) begin
        ch_pipe_r[i]  <= '0;
        row_pipe_r[i] <= '0;
      end
    end else begin
      calc_valid    <= {calc_valid[CORE_DELAY-2:0], fire};
      ch_pipe_r[0]  <= fire_ch;
      row_pipe_r[0] <= fire_row;
      for (int i = 1; i < CORE_DELAY; i++) begin
        ch_pipe_r[i]  <= ch_pipe_r[i-1];
        row_pipe_r[i] <= row_pipe_r[i-1];
      end
      if (calc_valid[CORE_DELAY-1]) begin
        tag_ch  <= ch_pipe_r[CORE_DELAY-1];
        tag_row <= row_pipe_r[CORE_DELAY-1];
      end
    end
  end

endmodule

// File: rtl/bnn_core_feeder.sv
// Layer sequencer for bnn_core: per output channel loads the weight word, then
// streams every image row channel-interleaved with gaps, and raises calc strobes.
module bnn_core_feeder
  import bnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_img_rd_en,
  output logic [IMG_AW-1:0]        o_img_addr,
  input  logic [IN_DATA_WIDTH-1:0] i_img_rd_data,
  output logic                     o_wgt_rd_en,
  output logic [WGT_AW-1:0]        o_wgt_addr,
  input  logic [WEGT_SIZE-1:0]     i_wgt_rd_data,
  output logic [WEGT_SIZE-1:0]     o_weight,
  output logic [IN_DATA_WIDTH-1:0] o_data,
  output logic                     o_valid,
  output logic [CORE_DELAY-1:0]    o_calc_valid,
  output logic [WGT_AW-1:0]        o_tag_ch,
  output logic [ROW_W-1:0]         o_tag_row
);

  state_t            state_r, state_nx;
  logic [WGT_AW-1:0] ch_r, ch_nx;
  logic [ROW_W-1:0]  row_r, row_nx;
  logic [CHAN_W-1:0] chan_r, chan_nx;
  logic [GAP_W-1:0]  gap_r, gap_nx;
  logic              done_nx;

  logic              last_rd_r, fire_r;
  logic [WGT_AW-1:0] last_ch_r, fire_ch_r;
  logic [ROW_W-1:0]  last_row_r, fire_row_r;

  // State and loop counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      ch_r    <= '0;
      row_r   <= '0;
      chan_r  <= '0;
      gap_r   <= '0;
    end else begin
      state_r <= state_nx;
      ch_r    <= ch_nx;
      row_r   <= row_nx;
      chan_r  <= chan_nx;
      gap_r   <= gap_nx;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_nx = state_r;
    ch_nx    = ch_r;
    row_nx   = row_r;
    chan_nx  = chan_r;
    gap_nx   = gap_r;
    done_nx  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (i_start) begin
          state_nx = S_WRD;
          ch_nx    = '0;
          row_nx   = '0;
          chan_nx  = '0;
          gap_nx   = '0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_WRD:  state_nx = S_WCAP;
      S_WCAP: begin
        state_nx = S_ROW;
        chan_nx  = '0;
      end
      S_ROW: begin
        if (chan_r == CHAN_W'(IN_CHANNEL - 1)) begin
          state_nx = S_GAP;
          gap_nx   = '0;
        end else begin
          chan_nx = chan_r + CHAN_W'(1);
        end
      end
      S_GAP: begin
        if (gap_r == GAP_W'(ROW_GAP - 1)) begin
          if (row_r < ROW_W'(IN_DATA_WIDTH - 1)) begin
            row_nx   = row_r + ROW_W'(1);
            chan_nx  = '0;
            state_nx = S_ROW;
          end else if (ch_r < WGT_AW'(OUT_CHANNEL - 1)) begin
            ch_nx    = ch_r + WGT_AW'(1);
            row_nx   = '0;
            state_nx = S_WRD;
          end else begin
            state_nx = S_DRAIN;
          end
        end else begin
          gap_nx = gap_r + GAP_W'(1);
        end
      end
      // Only the final row's strobe can still be in flight once here.
      S_DRAIN: begin
        if (o_calc_valid[CORE_DELAY-1]) begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = S_DRAIN;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Registered memory/control outputs, decoded from the upcoming state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_wgt_rd_en <= 1'b0;
      o_wgt_addr  <= '0;
      o_img_rd_en <= 1'b0;
      o_img_addr  <= '0;
      o_weight    <= '0;
      o_valid     <= 1'b0;
      last_rd_r   <= 1'b0;
      last_ch_r   <= '0;
      last_row_r  <= '0;
      fire_r      <= 1'b0;
      fire_ch_r   <= '0;
      fire_row_r  <= '0;
    end else begin
      o_busy      <= (state_nx != S_IDLE);
      o_done      <= done_nx;
      o_wgt_rd_en <= (state_nx == S_WRD);
      o_wgt_addr  <= ch_nx;
      o_img_rd_en <= (state_nx == S_ROW);
      o_img_addr  <= (state_nx == S_ROW) ? img_addr(row_nx, chan_nx) : '0;
      if (state_r == S_WCAP) begin
        o_weight <= i_wgt_rd_data;
      end
      o_valid     <= o_img_rd_en;
      // Priming rows fill the line buffer but produce no calc.
      last_rd_r   <= (state_nx == S_ROW) && (chan_nx == CHAN_W'(IN_CHANNEL - 1)) &&
                     (row_nx >= ROW_W'(WEGT_WIDTH - 1));
      last_ch_r   <= ch_nx;
      last_row_r  <= row_nx - ROW_W'(WEGT_WIDTH - 1);
      fire_r      <= last_rd_r;
      fire_ch_r   <= last_ch_r;
      fire_row_r  <= last_row_r;
    end
  end

  // Read data arrives one cycle after rd_en, already aligned with o_valid.
  assign o_data = o_valid ? i_img_rd_data : '0;

  bnn_calc_strobe_gen u_strobe (
    .clk        (clk),
    .reset_n    (reset_n),
    .fire       (fire_r),
    .fire_ch    (fire_ch_r),
    .fire_row   (fire_row_r),
    .calc_valid (o_calc_valid),
    .tag_ch     (o_tag_ch),
    .tag_row    (o_tag_row)
  );

endmodule

// File: tb/tb_bnn_core_feeder.sv
// Cycle-exact bench for bnn_core_feeder against a timing model derived from the
// layer schedule arithmetic, with randomized image and weight memories.
module tb_bnn_core_feeder;

  localparam int IC    = 3;
  localparam int OC    = 3;
  localparam int WW    = 3;
  localparam int IDW   = 28;
  localparam int WS    = 27;
  localparam int CD    = 5;
  localparam int GAP   = 2;
  localparam int IAW   = 7;
  localparam int WAW   = 2;
  localparam int ROW_T = IC + GAP;
  localparam int PASS  = 2 + IDW * ROW_T;
  localparam int NIMG  = IDW * IC;
  localparam int DONE_K = 1 + (OC - 1) * PASS + 2 + (IDW - 1) * ROW_T + (IC - 1) + 2 + CD;

  logic           clk;
  logic           reset_n;
  logic           i_start;
  logic           o_busy, o_done, o_img_rd_en, o_wgt_rd_en, o_valid;
  logic [IAW-1:0] o_img_addr;
  logic [WAW-1:0] o_wgt_addr, o_tag_ch;
  logic [IDW-1:0] i_img_rd_data, o_data;
  logic [WS-1:0]  i_wgt_rd_data, o_weight;
  logic [CD-1:0]  o_calc_valid;
  logic [4:0]     o_tag_row;

  bnn_core_feeder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_img_rd_en   (o_img_rd_en),
    .o_img_addr    (o_img_addr),
    .i_img_rd_data (i_img_rd_data),
    .o_wgt_rd_en   (o_wgt_rd_en),
    .o_wgt_addr    (o_wgt_addr),
    .i_wgt_rd_data (i_wgt_rd_data),
    .o_weight      (o_weight),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .o_calc_valid  (o_calc_valid),
    .o_tag_ch      (o_tag_ch),
    .o_tag_row     (o_tag_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [IDW-1:0] img_mem [NIMG];
  logic [WS-1:0]  wgt_mem [4];

  always @(posedge clk) begin
    if (o_img_rd_en) i_img_rd_data <= (int'(o_img_addr) < NIMG) ? img_mem[o_img_addr] : '0;
    if (o_wgt_rd_en) i_wgt_rd_data <= wgt_mem[o_wgt_addr];
  end

  int total = 0;
  int bad   = 0;
  logic [WS-1:0]  exp_weight;
  logic [WAW-1:0] exp_tag_ch;
  logic [4:0]     exp_tag_row;

  // Image read schedule, k cycles after the cycle holding i_start.
  function automatic void rd_model(input int k, output bit en, output int p, output int r, output int c);
    int j, q;
    en = 1'b0; p = 0; r = 0; c = 0;
    if (k >= 1) begin
      j = k - 1;
      p = j / PASS;
      q = j % PASS;
      if (p < OC && q >= 2 && ((q - 2) % ROW_T) < IC) begin
        en = 1'b1;
        r  = (q - 2) / ROW_T;
        c  = (q - 2) % ROW_T;
      end
    end
  endfunction

  // True when cycle k issues the final read of a row that yields a result.
  function automatic bit calc_read(input int k, output int p, output int r);
    bit en;
    int c;
    rd_model(k, en, p, r, c);
    return en && (c == IC - 1) && (r >= WW - 1);
  endfunction

  task automatic run_layer(input int re_a, input int re_b, input int abort_at, input int ncyc);
    bit en, aborted;
    int p, r, c, q;
    logic           e_busy, e_done, e_ire, e_wre, e_val, chk_waddr;
    logic [IAW-1:0] e_iaddr;
    logic [WAW-1:0] e_waddr;
    logic [IDW-1:0] e_data;
    logic [CD-1:0]  e_cv;
    for (int i = 0; i < NIMG; i++) img_mem[i] = IDW'($urandom);
    for (int i = 0; i < 4; i++) wgt_mem[i] = WS'($urandom);
    @(posedge clk); #1;
    i_start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      aborted = (abort_at >= 0) && (k >= abort_at);
      if (aborted) begin
        e_busy = 0; e_done = 0; e_ire = 0; e_wre = 0; e_val = 0;
        e_iaddr = '0; e_waddr = '0; e_data = '0; e_cv = '0; chk_waddr = 1'b1;
        exp_weight = '0; exp_tag_ch = '0; exp_tag_row = '0;
      end else begin
        rd_model(k, en, p, r, c);
        e_ire   = en;
        e_iaddr = en ? IAW'(r * IC + c) : '0;
        e_busy  = (k >= 1) && (k < DONE_K);
        e_done  = (k == DONE_K);
        e_wre   = (k >= 1) && ((k - 1) % PASS == 0) && ((k - 1) / PASS < OC);
        q = (k >= 1) ? (k - 1) / PASS : 0;
        if (q > OC - 1) q = OC - 1;
        e_waddr   = WAW'(q);
        chk_waddr = e_busy;
        rd_model(k - 1, en, p, r, c);
        e_val  = en;
        e_data = en ? img_mem[r * IC + c] : '0;
        for (int i = 0; i < CD; i++) e_cv[i] = calc_read(k - 2 - i, p, r);
        if (calc_read(k - 2 - CD, p, r)) begin
          exp_tag_ch  = WAW'(p);
          exp_tag_row = 5'(r - (WW - 1));
        end
        if (k >= 3 && ((k - 1) % PASS == 2) && ((k - 1) / PASS < OC))
          exp_weight = wgt_mem[(k - 1) / PASS];
      end
      total++; if (o_busy !== e_busy) begin bad++; $display("FAIL busy k=%0d got=%0b want=%0b", k, o_busy, e_busy); end
      total++; if (o_done !== e_done) begin bad++; $display("FAIL done k=%0d got=%0b want=%0b", k, o_done, e_done); end
      total++; if (o_img_rd_en !== e_ire) begin bad++; $display("FAIL img_rd_en k=%0d got=%0b want=%0b", k, o_img_rd_en, e_ire); end
      if (e_ire || aborted) begin
        total++; if (o_img_addr !== e_iaddr) begin bad++; $display("FAIL img_addr k=%0d got=%0d want=%0d", k, o_img_addr, e_iaddr); end
      end
      total++; if (o_wgt_rd_en !== e_wre) begin bad++; $display("FAIL wgt_rd_en k=%0d got=%0b want=%0b", k, o_wgt_rd_en, e_wre); end
      if (chk_waddr) begin
        total++; if (o_wgt_addr !== e_waddr) begin bad++; $display("FAIL wgt_addr k=%0d got=%0d want=%0d", k, o_wgt_addr, e_waddr); end
      end
      total++; if (o_valid !== e_val) begin bad++; $display("FAIL valid k=%0d got=%0b want=%0b", k, o_valid, e_val); end
      total++; if (o_data !== e_data) begin bad++; $display("FAIL data k=%0d got=%h want=%h", k, o_data, e_data); end
      total++; if (o_calc_valid !== e_cv) begin bad++; $display("FAIL calc_valid k=%0d got=%b want=%b", k, o_calc_valid, e_cv); end
      total++; if (o_tag_ch !== exp_tag_ch) begin bad++; $display("FAIL tag_ch k=%0d got=%0d want=%0d", k, o_tag_ch, exp_tag_ch); end
      total++; if (o_tag_row !== exp_tag_row) begin bad++; $display("FAIL tag_row k=%0d got=%0d want=%0d", k, o_tag_row, exp_tag_row); end
      total++; if (o_weight !== exp_weight) begin bad++; $display("FAIL weight k=%0d got=%h want=%h", k, o_weight, exp_weight); end
      @(posedge clk); #1;
      i_start = (k + 1 == re_a) || (k + 1 == re_b);
      if (abort_at >= 0 && k + 1 == abort_at) reset_n = 1'b0;
      if (abort_at >= 0 && k + 1 == abort_at + 3) reset_n = 1'b1;
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_start = 1'b0;
    exp_weight = '0; exp_tag_ch = '0; exp_tag_row = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({o_busy, o_done, o_img_rd_en, o_wgt_rd_en, o_valid} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {o_busy, o_done, o_img_rd_en, o_wgt_rd_en, o_valid});
    end
    total++; if (o_calc_valid !== '0) begin bad++; $display("FAIL reset_calc got=%b want=0", o_calc_valid); end
    total++; if ({o_img_addr, o_wgt_addr, o_tag_ch, o_tag_row} !== '0) begin
      bad++; $display("FAIL reset_addr_tag got=%h want=0", {o_img_addr, o_wgt_addr, o_tag_ch, o_tag_row});
    end
    total++; if ({o_weight, o_data} !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", {o_weight, o_data}); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", o_busy); end
  endtask

  task automatic test_full_layer();
    run_layer(-1, -1, -1, DONE_K + 8);
  endtask

  task automatic test_start_ignored();
    run_layer(50, 300, -1, DONE_K + 8);
  endtask

  task automatic test_back_to_back();
    run_layer(-1, -1, -1, DONE_K + 1);
    run_layer(-1, -1, -1, DONE_K + 4);
  endtask

  task automatic test_abort();
    run_layer(-1, -1, 200, 206);
    run_layer(-1, -1, -1, DONE_K + 4);
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
